// File: rtl/scatter.sv
// Round-robin work distributor: one upstream task stream fanned out to N solver
// lanes, each lane backed by a one-entry registered output stage.
module scatter #(
    parameter int width = 40,
    parameter int lanes = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [width-1:0]             m_data,
    input  logic                         m_valid,
    output logic                         m_ready,
    output logic [lanes*width-1:0]       s_data,
    output logic [lanes-1:0]             s_valid,
    input  logic [lanes-1:0]             s_ready,
    output logic [$clog2(lanes+1)-1:0]   occupancy,
    output logic [$clog2(lanes)-1:0]     last_lane
);

    localparam int PW = $clog2(lanes);
    localparam int IW = PW + 1;
    localparam int OW = $clog2(lanes + 1);
    localparam logic [IW-1:0] LANES_W = IW'(lanes);
    localparam logic [PW-1:0] LAST    = PW'(lanes - 1);

    logic [lanes-1:0] lv;
    logic [width-1:0] ld [lanes];
    logic [PW-1:0]    ptr;

    logic             found;
    logic [PW-1:0]    target;
    logic [IW-1:0]    idx;
    logic             accept;
    logic [lanes-1:0] drain;
    logic [lanes-1:0] lv_set;
    logic [lanes-1:0] lv_next;
    logic [OW-1:0]    drain_count;
    logic [OW-1:0]    occ_next;
    logic [PW-1:0]    ptr_next;

    // Ready depends only on registered lane state, never on downstream ready.
    assign m_ready = |(~lv);
    assign accept  = m_valid & m_ready;
    assign s_valid = lv;

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        assign s_data[i*width +: width] = ld[i];
    end

    // Scan from ptr (wrapping) for the first lane empty at the start of the cycle.
    always_comb begin
        found  = 1'b0;
        target = '0;
        idx    = '0;
        for (int k = 0; k < lanes; k++) begin
            idx = {1'b0, ptr} + IW'(k);
            if (idx >= LANES_W) begin
                idx = idx - LANES_W;
            end
            if (!found && !lv[idx[PW-1:0]]) begin
                found  = 1'b1;
                target = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        drain  = lv & s_ready;
        lv_set = '0;
        if (accept) begin
            lv_set[target] = 1'b1;
        end
        lv_next = (lv & ~drain) | lv_set;

        drain_count = '0;
        for (int i = 0; i < lanes; i++) begin
            drain_count = drain_count + OW'(drain[i]);
        end
        occ_next = occupancy - drain_count + OW'(accept);

        ptr_next = ptr;
        if (accept) begin
            ptr_next = (target == LAST) ? '0 : target + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lv        <= '0;
            ptr       <= '0;
            occupancy <= '0;
            last_lane <= '0;
        end else begin
            lv        <= lv_next;
            ptr       <= ptr_next;
            occupancy <= occ_next;
            if (accept) begin
                last_lane <= target;
            end
        end
    end

    // Payload registers carry no reset; their contents only matter while lv is set.
    always_ff @(posedge clock) begin
        for (int i = 0; i < lanes; i++) begin
            if (accept && target == PW'(i)) begin
                ld[i] <= m_data;
            end
        end
    end

endmodule

// File: tb/tb_scatter.sv
// Directed checks on a two-lane scatter plus a randomized four-lane run
// against a behavioural model and per-lane scoreboards.
module tb_scatter;

    localparam int W = 40;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic [2*W-1:0] s_data;
    logic [1:0]    s_valid;
    logic [1:0]    s_ready;
    logic [1:0]    occupancy;
    logic [0:0]    last_lane;

    logic          r_reset;
    logic [W-1:0]  r_m_data;
    logic          r_m_valid;
    logic          r_m_ready;
    logic [4*W-1:0] r_s_data;
    logic [3:0]    r_s_valid;
    logic [3:0]    r_s_ready;
    logic [2:0]    r_occupancy;
    logic [1:0]    r_last_lane;

    int tests = 0;
    int fails = 0;

    scatter #(.width(W), .lanes(2)) dut2 (
        .clock(clock), .reset(reset),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .occupancy(occupancy), .last_lane(last_lane)
    );

    scatter #(.width(W), .lanes(4)) dut4 (
        .clock(clock), .reset(r_reset),
        .m_data(r_m_data), .m_valid(r_m_valid), .m_ready(r_m_ready),
        .s_data(r_s_data), .s_valid(r_s_valid), .s_ready(r_s_ready),
        .occupancy(r_occupancy), .last_lane(r_last_lane)
    );

    function automatic logic [W-1:0] lane_a(input int i);
        return s_data[i*W +: W];
    endfunction

    function automatic logic [W-1:0] lane_b(input int i);
        return r_s_data[i*W +: W];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; m_valid = 1'b0; m_data = '0; s_ready = 2'b00;
        tick(); tick();
        reset = 1'b0;
        tests++; if (s_valid !== 2'b00) begin fails++; $display("[TB] FAIL reset_s_valid got %b want 00", s_valid); end
        tests++; if (m_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_m_ready got %b want 1", m_ready); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL reset_occupancy got %0d want 0", occupancy); end
        tests++; if (last_lane !== 1'b0) begin fails++; $display("[TB] FAIL reset_last_lane got %0d want 0", last_lane); end
    endtask

    task automatic test_round_robin();
        s_ready = 2'b11; m_valid = 1'b1;
        for (int n = 0; n < 4; n++) begin
            int ln;
            ln = n % 2;
            m_data = W'(n + 1);
            tick();
            tests++; if (s_valid !== (2'b01 << ln)) begin fails++; $display("[TB] FAIL rr_valid[%0d] got %b want %b", n, s_valid, 2'b01 << ln); end
            tests++; if (lane_a(ln) !== W'(n + 1)) begin fails++; $display("[TB] FAIL rr_data[%0d] got %h want %h", n, lane_a(ln), W'(n + 1)); end
            tests++; if (last_lane !== 1'(ln)) begin fails++; $display("[TB] FAIL rr_last_lane[%0d] got %0d want %0d", n, last_lane, ln); end
            tests++; if (occupancy !== 2'd1) begin fails++; $display("[TB] FAIL rr_occupancy[%0d] got %0d want 1", n, occupancy); end
        end
        m_valid = 1'b0;
        tick();
        tests++; if (s_valid !== 2'b00) begin fails++; $display("[TB] FAIL rr_drained got %b want 00", s_valid); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("[TB] FAIL rr_occ_end got %0d want 0", occupancy); end
    endtask

    task automatic test_full();
        s_ready = 2'b00; m_valid = 1'b1;
        m_data = W'('hAA); tick();
        m_data = W'('hBB); tick();
        tests++; if (s_valid !== 2'b11) begin fails++; $display("[TB] FAIL full_valid got %b want 11", s_valid); end
        tests++; if (occupancy !== 2'd2) begin fails++; $display("[TB] FAIL full_occ got %0d want 2", occupancy); end
        tests++; if (m_ready !== 1'b0) begin fails++; $display("[TB] FAIL full_m_ready got %b want 0", m_ready); end
        m_data = W'('hCC);
        for (int n = 0; n < 5; n++) begin
            tick();
            tests++; if (lane_a(0) !== W'('hAA) || lane_a(1) !== W'('hBB) || s_valid !== 2'b11)
                begin fails++; $display("[TB] FAIL full_hold[%0d] got %h/%h %b want aa/bb 11", n, lane_a(0), lane_a(1), s_valid); end
            tests++; if (occupancy !== 2'd2) begin fails++; $display("[TB] FAIL full_hold_occ[%0d] got %0d want 2", n, occupancy); end
        end
        s_ready = 2'b10;
        tick();
        tests++; if (s_valid !== 2'b01) begin fails++; $display("[TB] FAIL full_free1 got %b want 01", s_valid); end
        tests++; if (occupancy !== 2'd1) begin fails++; $display("[TB] FAIL full_free1_occ got %0d want 1", occupancy); end
        tests++; if (m_ready !== 1'b1) begin fails++; $display("[TB] FAIL full_free1_ready got %b want 1", m_ready); end
        s_ready = 2'b00;
        tick();
        m_valid = 1'b0;
        tests++; if (s_valid !== 2'b11 || lane_a(1) !== W'('hCC)) begin fails++; $display("[TB] FAIL full_cc got %b %h want 11 cc", s_valid, lane_a(1)); end
        tests++; if (last_lane !== 1'b1) begin fails++; $display("[TB] FAIL full_cc_last got %0d want 1", last_lane); end
        tests++; if (lane_a(0) !== W'('hAA)) begin fails++; $display("[TB] FAIL full_lane0_kept got %h want aa", lane_a(0)); end
    endtask

    task automatic test_skip_busy();
        s_ready = 2'b10; m_valid = 1'b0;
        tick();
        tests++; if (s_valid !== 2'b01) begin fails++; $display("[TB] FAIL skip_setup got %b want 01", s_valid); end
        s_ready = 2'b00; m_valid = 1'b1; m_data = W'('h10);
        tick();
        tests++; if (s_valid !== 2'b11 || lane_a(1) !== W'('h10)) begin fails++; $display("[TB] FAIL skip_10 got %b %h want 11 10", s_valid, lane_a(1)); end
        tests++; if (last_lane !== 1'b1) begin fails++; $display("[TB] FAIL skip_10_last got %0d want 1", last_lane); end
        m_valid = 1'b0; s_ready = 2'b10;
        tick();
        m_valid = 1'b1; m_data = W'('h11); s_ready = 2'b00;
        tick();
        tests++; if (s_valid !== 2'b11 || lane_a(1) !== W'('h11)) begin fails++; $display("[TB] FAIL skip_11 got %b %h want 11 11", s_valid, lane_a(1)); end
        tests++; if (lane_a(0) !== W'('hAA)) begin fails++; $display("[TB] FAIL skip_lane0_stable got %h want aa", lane_a(0)); end
        m_valid = 1'b0; s_ready = 2'b11;
        tick();
        m_valid = 1'b1; m_data = W'('h12); s_ready = 2'b00;
        tick();
        m_valid = 1'b0;
        tests++; if (s_valid !== 2'b01 || lane_a(0) !== W'('h12)) begin fails++; $display("[TB] FAIL skip_ptr0 got %b %h want 01 12", s_valid, lane_a(0)); end
        tests++; if (last_lane !== 1'b0) begin fails++; $display("[TB] FAIL skip_ptr0_last got %0d want 0", last_lane); end
    endtask

    task automatic test_full_drain();
        m_valid = 1'b1; m_data = W'('h20); s_ready = 2'b00;
        tick();
        tests++; if (occupancy !== 2'd2 || lane_a(1) !== W'('h20)) begin fails++; $display("[TB] FAIL fd_fill got %0d %h want 2 20", occupancy, lane_a(1)); end
        m_data = W'('h21); s_ready = 2'b11;
        tests++; if (m_ready !== 1'b0) begin fails++; $display("[TB] FAIL fd_ready_full got %b want 0", m_ready); end
        tick();
        tests++; if (s_valid !== 2'b00 || occupancy !== 2'd0) begin fails++; $display("[TB] FAIL fd_drain got %b %0d want 00 0", s_valid, occupancy); end
        s_ready = 2'b00;
        tick();
        m_valid = 1'b0;
        tests++; if (s_valid !== 2'b01 || lane_a(0) !== W'('h21)) begin fails++; $display("[TB] FAIL fd_accept got %b %h want 01 21", s_valid, lane_a(0)); end
        tests++; if (occupancy !== 2'd1) begin fails++; $display("[TB] FAIL fd_occ got %0d want 1", occupancy); end
    endtask

    task automatic test_reset_mid();
        s_ready = 2'b01; m_valid = 1'b0;
        tick();
        s_ready = 2'b00; m_valid = 1'b1;
        m_data = W'('h30); tick();
        m_data = W'('h31); tick();
        tests++; if (occupancy !== 2'd2 || lane_a(1) !== W'('h30) || lane_a(0) !== W'('h31))
            begin fails++; $display("[TB] FAIL rm_fill got %0d %h %h want 2 30 31", occupancy, lane_a(1), lane_a(0)); end
        reset = 1'b1; m_data = W'('h32);
        tick();
        reset = 1'b0;
        tests++; if (s_valid !== 2'b00 || occupancy !== 2'd0) begin fails++; $display("[TB] FAIL rm_cleared got %b %0d want 00 0", s_valid, occupancy); end
        tests++; if (m_ready !== 1'b1) begin fails++; $display("[TB] FAIL rm_ready got %b want 1", m_ready); end
        m_data = W'('h33);
        tick();
        m_valid = 1'b0;
        tests++; if (s_valid !== 2'b01 || lane_a(0) !== W'('h33)) begin fails++; $display("[TB] FAIL rm_first got %b %h want 01 33", s_valid, lane_a(0)); end
        tests++; if (last_lane !== 1'b0) begin fails++; $display("[TB] FAIL rm_last got %0d want 0", last_lane); end
    endtask

    task automatic test_random();
        bit           mv [4];
        logic [W-1:0] md [4];
        logic [W-1:0] exp_q [4][$];
        bit           prev_hold [4];
        logic [W-1:0] prev_data [4];
        int mptr, mocc, mlast, seq, n_in, n_out;
        mptr = 0; mocc = 0; mlast = 0; seq = 0; n_in = 0; n_out = 0;
        for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = '0; prev_hold[i] = 1'b0; prev_data[i] = '0; end
        r_reset = 1'b1; r_m_valid = 1'b0; r_m_data = '0; r_s_ready = 4'h0;
        tick(); tick();
        r_reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            int tgt;
            bit mrdy;
            bit dr [4];
            mrdy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!mv[i]) mrdy = 1'b1;
                tests++; if (r_s_valid[i] !== mv[i]) begin fails++; $display("[TB] FAIL rnd_valid c%0d l%0d got %b want %b", c, i, r_s_valid[i], mv[i]); end
                if (mv[i]) begin
                    tests++; if (lane_b(i) !== md[i]) begin fails++; $display("[TB] FAIL rnd_data c%0d l%0d got %h want %h", c, i, lane_b(i), md[i]); end
                end
                if (prev_hold[i]) begin
                    tests++; if (lane_b(i) !== prev_data[i]) begin fails++; $display("[TB] FAIL rnd_stable c%0d l%0d got %h want %h", c, i, lane_b(i), prev_data[i]); end
                end
            end
            tests++; if (r_m_ready !== mrdy) begin fails++; $display("[TB] FAIL rnd_m_ready c%0d got %b want %b", c, r_m_ready, mrdy); end
            tests++; if (r_occupancy !== 3'(mocc)) begin fails++; $display("[TB] FAIL rnd_occ c%0d got %0d want %0d", c, r_occupancy, mocc); end
            tests++; if (r_occupancy !== 3'($countones(r_s_valid))) begin fails++; $display("[TB] FAIL rnd_occ_pop c%0d got %0d want %0d", c, r_occupancy, $countones(r_s_valid)); end
            tests++; if (r_last_lane !== 2'(mlast)) begin fails++; $display("[TB] FAIL rnd_last c%0d got %0d want %0d", c, r_last_lane, mlast); end

            r_m_valid = ($urandom_range(0, 3) != 0);
            r_m_data  = {8'hA5, 32'(seq)};
            for (int i = 0; i < 4; i++) r_s_ready[i] = ($urandom_range(0, 1) == 1);

            for (int i = 0; i < 4; i++) begin
                dr[i] = mv[i] && r_s_ready[i];
                if (r_s_valid[i] && r_s_ready[i]) begin
                    tests++;
                    if (exp_q[i].size() == 0) begin
                        fails++; $display("[TB] FAIL rnd_sb_extra c%0d l%0d got %h want none", c, i, lane_b(i));
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q[i].pop_front();
                        n_out++;
                        if (lane_b(i) !== e) begin fails++; $display("[TB] FAIL rnd_sb_order c%0d l%0d got %h want %h", c, i, lane_b(i), e); end
                    end
                end
                prev_hold[i] = r_s_valid[i] && !r_s_ready[i];
                prev_data[i] = lane_b(i);
            end

            tgt = -1;
            if (r_m_valid && mrdy) begin
                for (int k = 0; k < 4; k++) begin
                    if (tgt < 0 && !mv[(mptr + k) % 4]) tgt = (mptr + k) % 4;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (dr[i]) begin mv[i] = 1'b0; mocc--; end
            end
            if (tgt >= 0) begin
                mv[tgt] = 1'b1; md[tgt] = r_m_data; mocc++;
                exp_q[tgt].push_back(r_m_data);
                mptr = (tgt + 1) % 4; mlast = tgt;
                seq++; n_in++;
            end
            tick();
        end
        r_m_valid = 1'b0; r_s_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (r_s_valid[i]) begin
                tests++;
                if (exp_q[i].size() == 0) begin
                    fails++; $display("[TB] FAIL rnd_tail_extra l%0d got %h want none", i, lane_b(i));
                end else begin
                    logic [W-1:0] e;
                    e = exp_q[i].pop_front();
                    n_out++;
                    if (lane_b(i) !== e) begin fails++; $display("[TB] FAIL rnd_tail_order l%0d got %h want %h", i, lane_b(i), e); end
                end
            end
        end
        tick();
        tests++; if (r_s_valid !== 4'h0) begin fails++; $display("[TB] FAIL rnd_final_valid got %b want 0000", r_s_valid); end
        tests++; if (n_out !== n_in) begin fails++; $display("[TB] FAIL rnd_count got %0d out want %0d in", n_out, n_in); end
        tests++; if (n_in < 1000) begin fails++; $display("[TB] FAIL rnd_traffic got %0d accepts want at least 1000", n_in); end
    endtask

    initial begin
        reset = 1'b1; m_valid = 1'b0; m_data = '0; s_ready = 2'b00;
        r_reset = 1'b1; r_m_valid = 1'b0; r_m_data = '0; r_s_ready = 4'h0;
        test_reset();
        test_round_robin();
        test_full();
        test_skip_busy();
        test_full_drain();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scatter.md
Name: scatter

Overview:
- Work distributor that is the counterpart of the two-way result gather.
- Takes one task stream from the board/task generator and dispatches each task to one of N solver lanes.
- Lane choice is round-robin and work-conserving.
- Each lane has a one-entry registered output stage, so no combinational path exists between any downstream s_ready and upstream m_ready.

Parameters:
- width, 40, bits per task word (packed board/task data).
- lanes, 2, number of downstream solver lanes (legal range 2..16).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- m_data  input  width  upstream task word.
- m_valid  input  1  upstream word valid.
- m_ready  output  1  scatter can accept a word this cycle.
- s_data  output  lanes*width  lane i data at bits [i*width +: width].
- s_valid  output  lanes  per-lane valid.
- s_ready  input  lanes  per-lane ready from solver.
- occupancy  output  $clog2(lanes+1)  number of lane registers currently holding a task.
- last_lane  output  $clog2(lanes)  lane that received the most recent accepted task.

Behaviour:
- **Interface basics.**
  - One clock. Reset is synchronous and active-high, sampled on posedge clock.
  - Handshake is valid/ready: a transfer occurs on a cycle where valid && ready at posedge.
- **State.**
  - Per lane: valid bit lv[i] and data register ld[i].
  - Round-robin pointer ptr, range 0..lanes-1.
  - occupancy counter.
  - last_lane register.
- **Reset values.**
  - lv = 0, ptr = 0, occupancy = 0, last_lane = 0.
  - Data registers are not reset.
  - Resulting outputs: s_valid = 0, m_ready = 1.
  - A reset asserted mid-operation drops all held tasks with no drain.
- **Outputs.**
  - s_valid[i] = lv[i]; s_data lane i = ld[i].
  - m_ready = OR over i of !lv[i].
  - m_ready depends only on registered state, never on s_ready or m_valid.
- **Drain.**
  - When s_valid[i] && s_ready[i], lv[i] clears at the next edge.
  - A solver holding s_ready low keeps lv[i] and ld[i] stable indefinitely.
- **Accept.**
  - When m_valid && m_ready, the target lane t is the first i in ptr, ptr+1, ..., ptr+lanes-1 (mod lanes) with lv[i] == 0 at the start of the cycle.
  - At the next edge: ld[t] <= m_data, lv[t] <= 1, ptr <= (t+1) mod lanes, last_lane <= t.
- **Simultaneous drain and accept.**
  - A lane being drained in the same cycle is not eligible for that cycle's write. Eligibility uses start-of-cycle lv.
  - A lane can therefore be refilled no earlier than one cycle after it empties, which gives a one-bubble refill per lane.
- **Pointer.** ptr changes only on accept and wraps from lanes-1 to 0.
- **Occupancy.**
  - +1 on accept only, -1 on drain only.
  - Unchanged when one accept and one drain happen in the same cycle.
  - With multiple lanes draining in one cycle, decrement by the popcount of drains, and add 1 if there is also an accept.
  - Never exceeds lanes.
- **Latency.** Accept at edge k gives s_valid[t] high from cycle k+1.
- **Ordering.**
  - Per-lane order is preserved.
  - No ordering is guaranteed across lanes; the gather side is order-agnostic.
- **Full condition.** When all lanes are occupied, m_ready = 0 and m_data is ignored even if m_valid is high.

Test Plan:
- Reset, then m_valid=1 with data 0x01, 0x02, 0x03, 0x04 back-to-back, s_ready=2'b11 → lane0 gets 0x01, lane1 0x02, lane0 0x03, lane1 0x04. Each item appears one cycle after accept. last_lane alternates 0,1,0,1.
- s_ready=2'b00, push 0xAA, 0xBB → both lanes hold data, occupancy=2, m_ready=0. A third word 0xCC held on m_valid for 5 cycles is not accepted and lanes are unchanged. Raising s_ready[1] frees lane1 next cycle, and 0xCC lands in lane1 the cycle after.
- Lane0 stalled (s_ready[0]=0, lv[0]=1), ptr=0, push 0x10, 0x11 → both go to lane1 (skip busy lane). ptr stays at 0 after each, so lane0 is tried first again once it frees.
- Full, both lanes drain in the same cycle that m_valid=1 → no accept that cycle (m_ready=0). Next cycle accept into lane ptr. occupancy goes 2→0→1.
- Mid-stream synchronous reset with occupancy=2 → next edge gives s_valid=0, occupancy=0, ptr=0, m_ready=1. The first post-reset word goes to lane0.
- lanes=4, random m_valid/s_ready for 10k cycles → scoreboard checks:
  - every accepted word emerges exactly once;
  - per-lane order is preserved;
  - occupancy equals the popcount of s_valid every cycle;
  - no s_data change while s_valid && !s_ready.
